calc1_port_responder: RTL and testbench

Single-channel responder for the calc1 request/response protocol: captures a command with operand 1, captures operand 2 on the following cycle, computes the result and returns a one-cycle response with data. It is the serving end of the interface our calc1 benches drive. It is the building block for a multi-port calculator or a golden responder in loop-back benches. One request is outstanding at a time.

---
 rtl/calc1_pkg.sv | 34 +++
 rtl/calc1_alu.sv | 68 ++++++
 rtl/calc1_port_responder.sv | 110 +++++++++++
 tb/tb_calc1_port_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc1_pkg
//  Description : Shared command/response codes, FSM state and width defaults
//                for the calc1 responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc1_pkg;

    localparam int CALC1_DATA_W = 32;
    localparam int CALC1_CMD_W  = 4;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    typedef enum logic [1:0] {
        RESP_NONE   = 2'd0,
        RESP_OK     = 2'd1,
        RESP_ERR    = 2'd2,
        RESP_UNUSED = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPND2 = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage : calc1_pkg
`default_nettype wire

// File: rtl/calc1_alu.sv
`default_nettype none
// ============================================================================
//  Module      : calc1_alu
//  Description : Combinational add/sub/shift unit; the shifter is only built
//                when CALC1_SHIFT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc1_alu
    import calc1_pkg::*;
#(
    parameter int DATA_W = CALC1_DATA_W,
    parameter int CMD_W  = CALC1_CMD_W
) (
    input  logic [CMD_W-1:0]  cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output resp_e             resp,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W:0] w_sum;
    assign w_sum = {1'b0, op1} + {1'b0, op2};

`ifdef CALC1_SHIFT_EN
    // Shift amount is the low five bits of operand 2 regardless of width.
    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_shl;
    logic [DATA_W-1:0] w_shr;
    assign w_shamt = op2[4:0];
    assign w_shl   = op1 << w_shamt;
    assign w_shr   = op1 >> w_shamt;
`endif

    always_comb begin
        resp = RESP_ERR;
        data = '0;
        case (cmd)
            CMD_W'(CMD_ADD): begin
                if (!w_sum[DATA_W]) begin
                    resp = RESP_OK;
                    data = w_sum[DATA_W-1:0];
                end
            end
            CMD_W'(CMD_SUB): begin
                if (op2 <= op1) begin
                    resp = RESP_OK;
                    data = op1 - op2;
                end
            end
`ifdef CALC1_SHIFT_EN
            CMD_W'(CMD_SHL): begin
                resp = RESP_OK;
                data = w_shl;
            end
            CMD_W'(CMD_SHR): begin
                resp = RESP_OK;
                data = w_shr;
            end
`endif
            default: begin
                resp = RESP_ERR;
                data = '0;
            end
        endcase
    end

endmodule : calc1_alu
`default_nettype wire

// File: rtl/calc1_port_responder.sv
`default_nettype none
// ============================================================================
//  Module      : calc1_port_responder
//  Description : Single-channel calc1 responder: command+op1, op2, execute,
//                one-cycle registered response. Shift support: CALC1_SHIFT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int DATA_W = CALC1_DATA_W,
    parameter int CMD_W  = CALC1_CMD_W
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  req_cmd_in,
    input  logic [DATA_W-1:0] req_data_in,
    output logic [1:0]        out_resp,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    state_e            r_state;
    state_e            w_next;
    logic [CMD_W-1:0]  r_cmd;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    resp_e             r_resp;
    logic [DATA_W-1:0] r_data;
    resp_e             w_alu_resp;
    logic [DATA_W-1:0] w_alu_data;
    logic              w_cmd_valid;
    logic              w_busy;

    assign w_cmd_valid = |req_cmd_in;

    calc1_alu #(
        .DATA_W (DATA_W),
        .CMD_W  (CMD_W)
    ) u_alu (
        .cmd  (r_cmd),
        .op1  (r_op1),
        .op2  (r_op2),
        .resp (w_alu_resp),
        .data (w_alu_data)
    );

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_cmd_valid ? ST_OPND2 : ST_IDLE;
            ST_OPND2: w_next = ST_EXEC;
            ST_EXEC:  w_next = ST_RESP;
            ST_RESP:  w_next = w_cmd_valid ? ST_OPND2 : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        if ((r_state == ST_OPND2) || (r_state == ST_EXEC)) begin
            w_busy = 1'b1;
        end
    end

    // Response registers are loaded only in EXEC, so they are nonzero for
    // exactly the single RESP cycle that follows.
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            r_cmd  <= '0;
            r_op1  <= '0;
            r_op2  <= '0;
            r_resp <= RESP_NONE;
            r_data <= '0;
        end else begin
            r_resp <= RESP_NONE;
            r_data <= '0;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_cmd_valid) begin
                        r_cmd <= req_cmd_in;
                        r_op1 <= req_data_in;
                    end
                end
                ST_OPND2: begin
                    r_op2 <= req_data_in;
                end
                ST_EXEC: begin
                    r_resp <= w_alu_resp;
                    r_data <= w_alu_data;
                end
                default: ;
            endcase
        end
    end

    assign out_resp = r_resp;
    assign out_data = r_data;
    assign busy     = w_busy;

endmodule : calc1_port_responder
`default_nettype wire

// File: tb/tb_calc1_port_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc1_port_responder
//  Description : Directed self-checking bench for calc1_port_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc1_port_responder;

    logic        c_clk;
    logic        reset;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic        busy;

    int n_assert;
    int n_fail;

    calc1_port_responder dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .busy        (busy)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts on a cycle where the FSM can accept; ends in the RESP cycle.
    task automatic run_req(input string tag, input logic [3:0] cmd,
                           input logic [31:0] op1, input logic [31:0] op2,
                           input logic [3:0] junk_cmd,
                           input logic [1:0] exp_resp, input logic [31:0] exp_data);
        req_cmd_in  = cmd;
        req_data_in = op1;
        step();
        check({tag, "_opnd2_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_opnd2_resp"}, {30'd0, out_resp}, 32'd0);
        req_cmd_in  = junk_cmd;
        req_data_in = op2;
        step();
        check({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_exec_resp"}, {30'd0, out_resp}, 32'd0);
        req_data_in = 32'd0;
        step();
        req_cmd_in = 4'd0;
        check({tag, "_resp"}, {30'd0, out_resp}, {30'd0, exp_resp});
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_resp_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_idle(input string tag);
        step();
        check({tag, "_clr_resp"}, {30'd0, out_resp}, 32'd0);
        check({tag, "_clr_data"}, out_data, 32'd0);
        check({tag, "_clr_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;

        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_resp", {30'd0, out_resp}, 32'd0);
            check("rst_data", out_data, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
        end
        reset = 1'b1;
        step();

        run_req("add_first", 4'd1, 32'd1, 32'h01FF_FFFF, 4'd0, 2'd1, 32'h0200_0000);
        expect_idle("add_first");

        run_req("add_carry", 4'd1, 32'hFFFF_FFFF, 32'd1, 4'd0, 2'd2, 32'd0);
        expect_idle("add_carry");
        run_req("add_big", 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 4'd0, 2'd1, 32'h3FFF_FFFE);
        expect_idle("add_big");

        run_req("sub_under", 4'd2, 32'd1, 32'hF, 4'd0, 2'd2, 32'd0);
        expect_idle("sub_under");
        run_req("sub_equal", 4'd2, 32'd5, 32'd5, 4'd0, 2'd1, 32'd0);
        expect_idle("sub_equal");
        run_req("sub_normal", 4'd2, 32'd100, 32'd58, 4'd0, 2'd1, 32'd42);
        expect_idle("sub_normal");

        run_req("inv_cmd3", 4'd3, 32'd1, 32'd1, 4'd0, 2'd2, 32'd0);
        expect_idle("inv_cmd3");
        run_req("inv_cmd4", 4'd4, 32'd1, 32'd1, 4'd0, 2'd2, 32'd0);
        expect_idle("inv_cmd4");
        run_req("inv_cmd15", 4'd15, 32'd9, 32'd9, 4'd0, 2'd2, 32'd0);
        expect_idle("inv_cmd15");

`ifdef CALC1_SHIFT_EN
        run_req("shl", 4'd5, 32'd1, 32'h21, 4'd0, 2'd1, 32'd2);
        expect_idle("shl");
        run_req("shr", 4'd6, 32'h8000_0000, 32'h1F, 4'd0, 2'd1, 32'd1);
        expect_idle("shr");
        run_req("shl_zero", 4'd5, 32'h8000_0000, 32'd1, 4'd0, 2'd1, 32'd0);
        expect_idle("shl_zero");
`else
        run_req("shl", 4'd5, 32'd1, 32'h21, 4'd0, 2'd2, 32'd0);
        expect_idle("shl");
        run_req("shr", 4'd6, 32'h8000_0000, 32'h1F, 4'd0, 2'd2, 32'd0);
        expect_idle("shr");
`endif

        // Back-to-back: second command issued in the RESP cycle of the first,
        // with a junk command driven during its OPND2/EXEC cycles.
        run_req("b2b_first", 4'd1, 32'd2, 32'd3, 4'd0, 2'd1, 32'd5);
        run_req("b2b_second", 4'd1, 32'd4, 32'd4, 4'd2, 2'd1, 32'd8);
        expect_idle("b2b_after");
        expect_idle("b2b_quiet");

        // Reset asserted while an add is in EXEC drops it.
        req_cmd_in  = 4'd1;
        req_data_in = 32'd10;
        step();
        req_cmd_in  = 4'd0;
        req_data_in = 32'd20;
        step();
        check("mid_rst_exec_busy", {31'd0, busy}, 32'd1);
        reset       = 1'b0;
        req_data_in = 32'd0;
        step();
        check("mid_rst_resp", {30'd0, out_resp}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        step();
        check("mid_rst_after_resp", {30'd0, out_resp}, 32'd0);
        check("mid_rst_after_busy", {31'd0, busy}, 32'd0);
        run_req("post_rst_add", 4'd1, 32'd7, 32'd1, 4'd0, 2'd1, 32'd8);
        expect_idle("post_rst_add");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_calc1_port_responder
`default_nettype wire
